// File: rtl/range_det_pkg.sv
// Shared definitions for the multi-peak range detector.
// Holds the report beat layout (magic word, header and peak field offsets),
// the peak entry record used by the output buffer, the output FSM state type,
// and helpers that pack header and peak beats.
package range_det_pkg;

    localparam int unsigned OUT_WIDTH = 128;
    localparam logic [31:0] MAGIC     = 32'h504B504B;

    // Header beat fields
    localparam int unsigned HDR_MAGIC_LSB  = 0;
    localparam int unsigned HDR_PEAKS_LSB  = 32;
    localparam int unsigned HDR_FCOUNT_LSB = 40;
    localparam int unsigned HDR_ID_LSB     = 64;

    // Peak beat fields
    localparam int unsigned PK_VALUE_LSB = 0;
    localparam int unsigned PK_INDEX_LSB = 64;
    localparam int unsigned PK_RANK_LSB  = 96;

    // Entries are stored at the widest legal sizes so the packers stay unparameterised.
    typedef struct packed {
        logic [63:0] value;
        logic [31:0] index;
    } peak_entry_t;

    typedef enum logic [1:0] {
        StIdle,
        StHeader,
        StPeak
    } out_state_e;

    function automatic logic [OUT_WIDTH-1:0] pack_header(input logic [7:0]  peaks,
                                                         input logic [23:0] fcount,
                                                         input logic [63:0] id);
        logic [OUT_WIDTH-1:0] beat;
        beat = '0;
        beat[HDR_MAGIC_LSB  +: 32] = MAGIC;
        beat[HDR_PEAKS_LSB  +: 8]  = peaks;
        beat[HDR_FCOUNT_LSB +: 24] = fcount;
        beat[HDR_ID_LSB     +: 64] = id;
        return beat;
    endfunction

    function automatic logic [OUT_WIDTH-1:0] pack_peak(input peak_entry_t entry,
                                                       input logic [7:0]  rank);
        logic [OUT_WIDTH-1:0] beat;
        beat = '0;
        beat[PK_VALUE_LSB +: 64] = entry.value;
        beat[PK_INDEX_LSB +: 32] = entry.index;
        beat[PK_RANK_LSB  +: 8]  = rank;
        return beat;
    endfunction

endpackage

// File: rtl/peak_topn_sorter.sv
// Keeps the NUM_PEAKS largest candidates in descending value order.
// One candidate per cycle is inserted with a parallel compare-and-shift.
// A candidate lands after any slot of equal value, so on ties the earlier
// (already stored) index keeps the higher rank. clear empties every slot; when
// clear and insert coincide the candidate enters the freshly emptied list.
// Ports:
//   aclk, areset : clock, asynchronous active-high reset
//   insert       : candidate valid this cycle
//   value, index : candidate magnitude and sample index
//   clear        : empty all slots
//   slots        : flattened slots, slot i at [i*(DATA_WIDTH+INDEX_WIDTH)],
//                  value in the low DATA_WIDTH bits, index above it.
//                  Empty slots read value 0, index all-ones.
module peak_topn_sorter #(
    parameter int unsigned NUM_PEAKS   = 4,
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned INDEX_WIDTH = 32
) (
    input  logic                                          aclk,
    input  logic                                          areset,
    input  logic                                          insert,
    input  logic [DATA_WIDTH-1:0]                         value,
    input  logic [INDEX_WIDTH-1:0]                        index,
    input  logic                                          clear,
    output logic [NUM_PEAKS*(DATA_WIDTH+INDEX_WIDTH)-1:0] slots
);

    localparam int unsigned SLOT_W = DATA_WIDTH + INDEX_WIDTH;

    logic [DATA_WIDTH-1:0]  val_q [NUM_PEAKS];
    logic [INDEX_WIDTH-1:0] idx_q [NUM_PEAKS];
    logic [NUM_PEAKS-1:0]   full_q;

    logic [DATA_WIDTH-1:0]  val_d [NUM_PEAKS];
    logic [INDEX_WIDTH-1:0] idx_d [NUM_PEAKS];
    logic [NUM_PEAKS-1:0]   full_d;

    logic [DATA_WIDTH-1:0]  base_val;
    logic [INDEX_WIDTH-1:0] base_idx;
    logic                   base_full;
    logic                   beats;
    // Contents of the slot just above the one being computed (pre-insert view).
    logic [DATA_WIDTH-1:0]  carry_val;
    logic [INDEX_WIDTH-1:0] carry_idx;
    logic                   carry_full;
    logic                   carry_beats;

    always_comb begin
        carry_val   = '0;
        carry_idx   = '1;
        carry_full  = 1'b0;
        carry_beats = 1'b0;
        base_val    = '0;
        base_idx    = '1;
        base_full   = 1'b0;
        beats       = 1'b0;
        full_d      = '0;
        for (int i = 0; i < NUM_PEAKS; i++) begin
            base_val  = clear ? '0 : val_q[i];
            base_idx  = clear ? '1 : idx_q[i];
            base_full = clear ? 1'b0 : full_q[i];
            // Strict compare: equal values keep their place ahead of the candidate.
            beats     = !base_full || (value > base_val);

            val_d[i]  = base_val;
            idx_d[i]  = base_idx;
            full_d[i] = base_full;
            if (insert && beats) begin
                if (carry_beats) begin
                    val_d[i]  = carry_val;
                    idx_d[i]  = carry_idx;
                    full_d[i] = carry_full;
                end else begin
                    val_d[i]  = value;
                    idx_d[i]  = index;
                    full_d[i] = 1'b1;
                end
            end

            carry_val   = base_val;
            carry_idx   = base_idx;
            carry_full  = base_full;
            carry_beats = beats;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            full_q <= '0;
            for (int i = 0; i < NUM_PEAKS; i++) begin
                val_q[i] <= '0;
                idx_q[i] <= '1;
            end
        end else begin
            full_q <= full_d;
            for (int i = 0; i < NUM_PEAKS; i++) begin
                val_q[i] <= val_d[i];
                idx_q[i] <= idx_d[i];
            end
        end
    end

    always_comb begin
        slots = '0;
        for (int i = 0; i < NUM_PEAKS; i++) begin
            slots[i*SLOT_W +: DATA_WIDTH]              = val_q[i];
            slots[i*SLOT_W + DATA_WIDTH +: INDEX_WIDTH] = idx_q[i];
        end
    end

endmodule

// File: rtl/multi_peak_range_detector.sv
// Post-correlation range detector. Consumes one squared-magnitude frame per
// chirp, finds local maxima inside the range gate that meet the threshold,
// keeps the NUM_PEAKS strongest, and emits a header beat plus NUM_PEAKS ranked
// peak beats per frame on an AXI-Stream master.
// Ports:
//   aclk, areset          : clock, asynchronous active-high reset
//   s_axis_*              : sample stream in (tready is always 1)
//   threshold             : minimum peak value (captured on first beat)
//   gate_min, gate_max    : eligible index window (captured on first beat)
//   counter_id            : chirp ID for the header (captured on first beat)
//   m_axis_*              : report stream out
//   frame_count           : frames completed, wraps
//   frames_dropped        : reports lost to a busy output, saturates
module multi_peak_range_detector
    import range_det_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned INDEX_WIDTH = 32,
    parameter int unsigned NUM_PEAKS   = 4
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic [DATA_WIDTH-1:0]  s_axis_tdata,
    input  logic                   s_axis_tvalid,
    input  logic                   s_axis_tlast,
    output logic                   s_axis_tready,
    input  logic [DATA_WIDTH-1:0]  threshold,
    input  logic [INDEX_WIDTH-1:0] gate_min,
    input  logic [INDEX_WIDTH-1:0] gate_max,
    input  logic [63:0]            counter_id,
    output logic [127:0]           m_axis_tdata,
    output logic                   m_axis_tvalid,
    output logic                   m_axis_tlast,
    input  logic                   m_axis_tready,
    output logic [31:0]            frame_count,
    output logic [31:0]            frames_dropped
);

    localparam int unsigned SLOT_W    = DATA_WIDTH + INDEX_WIDTH;
    localparam logic [7:0]  LAST_RANK = 8'(NUM_PEAKS - 1);
    localparam logic [7:0]  MAX_PEAKS = 8'(NUM_PEAKS);

    assign s_axis_tready = 1'b1;

    // ---------------- Input tracking ----------------
    logic                   first_q;
    logic [INDEX_WIDTH-1:0] idx_q;
    // Held sample awaiting its right-hand neighbour.
    logic                   cur_valid_q;
    logic                   cur_last_q;
    logic [DATA_WIDTH-1:0]  cur_val_q;
    logic [DATA_WIDTH-1:0]  prev_val_q;
    logic [INDEX_WIDTH-1:0] cur_idx_q;
    // Per-frame configuration shadow.
    logic [DATA_WIDTH-1:0]  cfg_thr_q;
    logic [INDEX_WIDTH-1:0] cfg_gmin_q;
    logic [INDEX_WIDTH-1:0] cfg_gmax_q;
    logic [63:0]            cfg_id_q;
    // Qualifying peak count, saturating at NUM_PEAKS.
    logic [7:0]             cnt_q;
    logic [7:0]             cnt_next;
    logic [7:0]             done_peaks_q;
    logic [63:0]            done_id_q;
    logic                   frame_end_q;

    logic                   evaluate;
    logic                   frame_done;
    logic [DATA_WIDTH-1:0]  next_val;
    logic                   qualify;
    logic [INDEX_WIDTH-1:0] beat_idx;
    logic [DATA_WIDTH-1:0]  beat_prev;

    always_comb begin
        // The last sample is judged the cycle after tlast, with a zero right neighbour.
        evaluate   = cur_valid_q && (cur_last_q || s_axis_tvalid);
        frame_done = cur_valid_q && cur_last_q;
        next_val   = cur_last_q ? '0 : s_axis_tdata;
        qualify    = evaluate
                     && (cur_val_q > prev_val_q)
                     && (cur_val_q >= next_val)
                     && (cur_val_q >= cfg_thr_q)
                     && (cur_idx_q >= cfg_gmin_q)
                     && (cur_idx_q <= cfg_gmax_q);
        cnt_next   = (qualify && (cnt_q < MAX_PEAKS)) ? cnt_q + 8'd1 : cnt_q;
        beat_idx   = first_q ? '0 : idx_q;
        beat_prev  = first_q ? '0 : cur_val_q;
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            first_q      <= 1'b1;
            idx_q        <= '0;
            cur_valid_q  <= 1'b0;
            cur_last_q   <= 1'b0;
            cur_val_q    <= '0;
            prev_val_q   <= '0;
            cur_idx_q    <= '0;
            cfg_thr_q    <= '0;
            cfg_gmin_q   <= '0;
            cfg_gmax_q   <= '0;
            cfg_id_q     <= '0;
            cnt_q        <= '0;
            done_peaks_q <= '0;
            done_id_q    <= '0;
            frame_end_q  <= 1'b0;
        end else begin
            frame_end_q <= frame_done;
            if (frame_done) begin
                // Latch the finished frame's summary before a new first beat can
                // overwrite the configuration shadow.
                done_peaks_q <= cnt_next;
                done_id_q    <= cfg_id_q;
                cnt_q        <= '0;
            end else begin
                cnt_q <= cnt_next;
            end

            if (s_axis_tvalid) begin
                cur_valid_q <= 1'b1;
                cur_last_q  <= s_axis_tlast;
                cur_val_q   <= s_axis_tdata;
                prev_val_q  <= beat_prev;
                cur_idx_q   <= beat_idx;
                idx_q       <= beat_idx + 1'b1;
                first_q     <= s_axis_tlast;
                if (first_q) begin
                    cfg_thr_q  <= threshold;
                    cfg_gmin_q <= gate_min;
                    cfg_gmax_q <= gate_max;
                    cfg_id_q   <= counter_id;
                end
            end else if (frame_done) begin
                cur_valid_q <= 1'b0;
            end
        end
    end

    // ---------------- Sorter ----------------
    logic [NUM_PEAKS*SLOT_W-1:0] sorter_slots;

    peak_topn_sorter #(
        .NUM_PEAKS  (NUM_PEAKS),
        .DATA_WIDTH (DATA_WIDTH),
        .INDEX_WIDTH(INDEX_WIDTH)
    ) u_sorter (
        .aclk  (aclk),
        .areset(areset),
        .insert(qualify),
        .value (cur_val_q),
        .index (cur_idx_q),
        .clear (frame_end_q),
        .slots (sorter_slots)
    );

    // ---------------- Output buffer and FSM ----------------
    out_state_e  state_q, state_d;
    logic [7:0]  rank_q, rank_d;
    peak_entry_t buf_q [NUM_PEAKS];
    peak_entry_t sel_entry;
    logic [7:0]  buf_peaks_q;
    logic [23:0] buf_fcount_q;
    logic [63:0] buf_id_q;
    logic [31:0] frame_count_q;
    logic [31:0] frames_dropped_q;
    logic        load;
    logic        drop;

    assign load           = frame_end_q && (state_q == StIdle);
    assign drop           = frame_end_q && (state_q != StIdle);
    assign frame_count    = frame_count_q;
    assign frames_dropped = frames_dropped_q;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            frame_count_q    <= '0;
            frames_dropped_q <= '0;
            buf_peaks_q      <= '0;
            buf_fcount_q     <= '0;
            buf_id_q         <= '0;
            for (int r = 0; r < NUM_PEAKS; r++) begin
                buf_q[r].value <= '0;
                buf_q[r].index <= '1;
            end
        end else begin
            if (frame_end_q) begin
                frame_count_q <= frame_count_q + 32'd1;
            end
            if (drop && (frames_dropped_q != '1)) begin
                frames_dropped_q <= frames_dropped_q + 32'd1;
            end
            if (load) begin
                buf_peaks_q  <= done_peaks_q;
                buf_fcount_q <= 24'(frame_count_q + 32'd1);
                buf_id_q     <= done_id_q;
                for (int r = 0; r < NUM_PEAKS; r++) begin
                    buf_q[r].value <= 64'(sorter_slots[r*SLOT_W +: DATA_WIDTH]);
                    buf_q[r].index <= 32'(sorter_slots[r*SLOT_W + DATA_WIDTH +: INDEX_WIDTH]);
                end
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q <= StIdle;
            rank_q  <= '0;
        end else begin
            state_q <= state_d;
            rank_q  <= rank_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        rank_d        = rank_q;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tdata  = '0;
        sel_entry     = '0;
        for (int r = 0; r < NUM_PEAKS; r++) begin
            if (rank_q == 8'(r)) begin
                sel_entry = buf_q[r];
            end
        end

        case (state_q)
            StIdle: begin
                if (frame_end_q) begin
                    state_d = StHeader;
                    rank_d  = '0;
                end
            end
            StHeader: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = pack_header(buf_peaks_q, buf_fcount_q, buf_id_q);
                if (m_axis_tready) begin
                    state_d = StPeak;
                end
            end
            StPeak: begin
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = (rank_q == LAST_RANK);
                m_axis_tdata  = pack_peak(sel_entry, rank_q);
                if (m_axis_tready) begin
                    if (rank_q == LAST_RANK) begin
                        state_d = StIdle;
                        rank_d  = '0;
                    end else begin
                        rank_d = rank_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                rank_d  = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_multi_peak_range_detector.sv
// Bench for multi_peak_range_detector: directed scenarios plus randomized
// frames, each report compared against a model that lists qualifying peaks
// from the raw sample array and ranks them by value, earliest index first.
module tb_multi_peak_range_detector;

    localparam int unsigned DW = 64;
    localparam int unsigned IW = 32;
    localparam int unsigned NP = 4;
    localparam logic [31:0] MAGIC_W = 32'h504B504B;

    logic          aclk = 1'b0;
    logic          areset = 1'b1;
    logic [DW-1:0] s_axis_tdata = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tlast = 1'b0;
    logic          s_axis_tready;
    logic [DW-1:0] threshold = '0;
    logic [IW-1:0] gate_min = '0;
    logic [IW-1:0] gate_max = '0;
    logic [63:0]   counter_id = '0;
    logic [127:0]  m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic          m_axis_tready = 1'b1;
    logic [31:0]   frame_count;
    logic [31:0]   frames_dropped;

    multi_peak_range_detector #(
        .DATA_WIDTH (DW),
        .INDEX_WIDTH(IW),
        .NUM_PEAKS  (NP)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .threshold     (threshold),
        .gate_min      (gate_min),
        .gate_max      (gate_max),
        .counter_id    (counter_id),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .frame_count   (frame_count),
        .frames_dropped(frames_dropped)
    );

    always #5 aclk = ~aclk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          ready_mode = 1;  // 0 low, 1 high, 2 random
    logic [128:0] mon_q[$];
    logic        stalled = 1'b0;
    logic [127:0] stall_data = '0;
    logic [63:0] fr[$];
    logic [128:0] exp_beats[NP+1];
    int unsigned exp_fcount = 0;

    task automatic check_eq(input string tag, input logic [128:0] got, input logic [128:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(posedge aclk) begin
        #1;
        case (ready_mode)
            0:       m_axis_tready = 1'b0;
            1:       m_axis_tready = 1'b1;
            default: m_axis_tready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Output monitor: records accepted beats and checks data holds while stalled.
    always @(negedge aclk) begin
        if (areset) begin
            stalled <= 1'b0;
        end else begin
            if (stalled) begin
                check_eq("stall_hold", {m_axis_tvalid, m_axis_tdata}, {1'b1, stall_data});
            end
            if (m_axis_tvalid && m_axis_tready) begin
                mon_q.push_back({m_axis_tlast, m_axis_tdata});
            end
            stalled    <= m_axis_tvalid && !m_axis_tready;
            stall_data <= m_axis_tdata;
        end
    end

    task automatic scramble_cfg();
        threshold  = {$urandom, $urandom};
        gate_min   = $urandom;
        gate_max   = $urandom;
        counter_id = {$urandom, $urandom};
    endtask

    // Drives fr[] as one frame; config is presented on the first beat only.
    task automatic send_frame(input logic [63:0] thr, input logic [31:0] gmin,
                              input logic [31:0] gmax, input logic [63:0] id,
                              input bit bubbles, input bit with_last, input bit tail);
        for (int k = 0; k < fr.size(); k++) begin
            if (bubbles) begin
                while ($urandom_range(0, 3) == 0) begin
                    @(posedge aclk);
                    #1;
                    s_axis_tvalid = 1'b0;
                    s_axis_tlast  = 1'b0;
                end
            end
            @(posedge aclk);
            #1;
            if (k == 0) begin
                threshold  = thr;
                gate_min   = gmin;
                gate_max   = gmax;
                counter_id = id;
            end else begin
                scramble_cfg();
            end
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = fr[k];
            s_axis_tlast  = with_last && (k == fr.size() - 1);
        end
        if (tail) begin
            @(posedge aclk);
            #1;
            s_axis_tvalid = 1'b0;
            s_axis_tlast  = 1'b0;
            scramble_cfg();
        end
    endtask

    // Reference: list qualifying peaks, then pick the largest repeatedly
    // (earliest index wins a tie).
    task automatic build_expected(input logic [63:0] thr, input logic [31:0] gmin,
                                  input logic [31:0] gmax, input logic [63:0] id,
                                  input int unsigned fcount);
        logic [63:0] pv[$];
        logic [31:0] pi[$];
        logic [63:0] left, right;
        logic [23:0] fc;
        int n, found, best;
        n = fr.size();
        for (int k = 0; k < n; k++) begin
            left  = (k == 0) ? 64'd0 : fr[k-1];
            right = (k == n - 1) ? 64'd0 : fr[k+1];
            if (fr[k] > left && fr[k] >= right && fr[k] >= thr &&
                32'(k) >= gmin && 32'(k) <= gmax) begin
                pv.push_back(fr[k]);
                pi.push_back(32'(k));
            end
        end
        found = (pv.size() < NP) ? pv.size() : NP;
        fc = 24'(fcount);
        exp_beats[0] = {1'b0, id, fc, 8'(found), MAGIC_W};
        for (int r = 0; r < NP; r++) begin
            if (pv.size() == 0) begin
                exp_beats[r+1] = {(r == NP - 1), 24'd0, 8'(r), 32'hFFFF_FFFF, 64'd0};
            end else begin
                best = 0;
                for (int j = 1; j < pv.size(); j++) begin
                    if (pv[j] > pv[best]) best = j;
                end
                exp_beats[r+1] = {(r == NP - 1), 24'd0, 8'(r), pi[best], pv[best]};
                pv.delete(best);
                pi.delete(best);
            end
        end
    endtask

    task automatic compare_report(input string tag);
        int waited;
        logic [128:0] got;
        waited = 0;
        while (mon_q.size() < NP + 1 && waited < 3000) begin
            @(negedge aclk);
            waited++;
        end
        if (mon_q.size() < NP + 1) begin
            check_eq({tag, "_timeout"}, 129'(mon_q.size()), 129'(NP + 1));
            mon_q.delete();
        end else begin
            for (int b = 0; b <= NP; b++) begin
                got = mon_q.pop_front();
                check_eq($sformatf("%s_beat%0d", tag, b), got, exp_beats[b]);
            end
        end
    endtask

    task automatic fill(input int n, input logic [63:0] base);
        fr.delete();
        for (int k = 0; k < n; k++) fr.push_back(base);
    endtask

    task automatic run_frame(input string tag, input logic [63:0] thr, input logic [31:0] gmin,
                             input logic [31:0] gmax, input bit bubbles);
        logic [63:0] id;
        id = {$urandom, $urandom};
        send_frame(thr, gmin, gmax, id, bubbles, 1'b1, 1'b1);
        exp_fcount++;
        build_expected(thr, gmin, gmax, id, exp_fcount);
        compare_report(tag);
    endtask

    initial begin
        logic [63:0] id_a;
        logic [63:0] v;

        // Reset state
        repeat (3) @(posedge aclk);
        #1;
        @(negedge aclk);
        check_eq("rst_tready", 129'(s_axis_tready), 129'd1);
        check_eq("rst_tvalid", 129'({m_axis_tvalid, m_axis_tlast}), 129'd0);
        check_eq("rst_tdata", 129'(m_axis_tdata), 129'd0);
        check_eq("rst_counts", 129'({frame_count, frames_dropped}), 129'd0);
        @(posedge aclk);
        #1;
        areset = 1'b0;

        // 1: single peak plus output latency
        fill(16, 64'd10);
        fr[5] = 64'd1000;
        id_a = 64'h0123_4567_89AB_CDEF;
        send_frame(64'd100, 32'd0, 32'd15, id_a, 1'b0, 1'b1, 1'b1);
        @(negedge aclk);
        check_eq("lat_t1", 129'(m_axis_tvalid), 129'd0);
        @(negedge aclk);
        check_eq("lat_t2", 129'(m_axis_tvalid), 129'd0);
        @(negedge aclk);
        check_eq("lat_t3", 129'(m_axis_tvalid), 129'd1);
        exp_fcount++;
        build_expected(64'd100, 32'd0, 32'd15, id_a, exp_fcount);
        compare_report("single");

        // 2: ranking and ties
        fill(16, 64'd1);
        fr[2] = 64'd300; fr[6] = 64'd900; fr[9] = 64'd300; fr[12] = 64'd500; fr[14] = 64'd700;
        run_frame("rank", 64'd0, 32'd0, 32'd15, 1'b0);

        // 3: gate and threshold; next frame widens the gate
        fill(32, 64'd10);
        fr[3] = 64'd800; fr[20] = 64'd800; fr[10] = 64'd50;
        run_frame("gate", 64'd100, 32'd5, 32'd30, 1'b0);
        run_frame("gate_next", 64'd100, 32'd0, 32'd30, 1'b0);

        // 5: edges
        fill(1, 64'd5);
        run_frame("one_sample", 64'd5, 32'd0, 32'd15, 1'b0);
        fill(3, 64'd7);
        run_frame("plateau", 64'd0, 32'd0, 32'd15, 1'b0);

        // 4: backpressure and drop, two back-to-back frames
        ready_mode = 0;
        repeat (2) @(posedge aclk);
        fill(8, 64'd2);
        fr[3] = 64'd77;
        id_a = {$urandom, $urandom};
        send_frame(64'd0, 32'd0, 32'd7, id_a, 1'b0, 1'b1, 1'b0);
        build_expected(64'd0, 32'd0, 32'd7, id_a, exp_fcount + 1);
        fill(8, 64'd3);
        fr[5] = 64'd99;
        send_frame(64'd0, 32'd0, 32'd7, {$urandom, $urandom}, 1'b0, 1'b1, 1'b1);
        exp_fcount += 2;
        repeat (20) @(posedge aclk);
        @(negedge aclk);
        check_eq("drop_count", 129'(frames_dropped), 129'd1);
        check_eq("drop_fcount", 129'(frame_count), 129'(exp_fcount));
        ready_mode = 1;
        compare_report("held");
        repeat (20) @(posedge aclk);
        check_eq("no_extra", 129'(mon_q.size()), 129'd0);

        // 6: reset mid-frame
        fill(4, 64'd50);
        fr[1] = 64'd500;
        send_frame(64'd0, 32'd0, 32'd7, {$urandom, $urandom}, 1'b0, 1'b0, 1'b0);
        @(posedge aclk);
        #1;
        areset = 1'b1;
        s_axis_tvalid = 1'b0;
        @(posedge aclk);
        #1;
        areset = 1'b0;
        exp_fcount = 0;
        @(negedge aclk);
        check_eq("rst_mid_counts", 129'({frame_count, frames_dropped}), 129'd0);
        fill(8, 64'd4);
        fr[2] = 64'd60;
        run_frame("after_rst", 64'd0, 32'd0, 32'd7, 1'b0);
        repeat (10) @(posedge aclk);
        check_eq("after_rst_fcount", 129'(frame_count), 129'd1);
        check_eq("after_rst_extra", 129'(mon_q.size()), 129'd0);

        // Randomized frames with input bubbles and random output stalls
        ready_mode = 2;
        for (int f = 0; f < 40; f++) begin
            logic [63:0] thr;
            logic [31:0] gmin, gmax;
            bit wide;
            wide = ($urandom_range(0, 3) == 0);
            fr.delete();
            for (int k = 0; k < int'($urandom_range(1, 20)); k++) begin
                v = wide ? {$urandom, $urandom} : 64'($urandom_range(0, 15));
                fr.push_back(v);
            end
            thr  = wide ? {$urandom, $urandom} >> $urandom_range(0, 8)
                        : 64'($urandom_range(0, 10));
            gmin = 32'($urandom_range(0, 6));
            gmax = 32'($urandom_range(0, 24));
            run_frame($sformatf("rand%0d", f), thr, gmin, gmax, 1'b1);
        end
        ready_mode = 1;
        repeat (10) @(posedge aclk);
        @(negedge aclk);
        check_eq("final_fcount", 129'(frame_count), 129'(exp_fcount));
        check_eq("final_dropped", 129'(frames_dropped), 129'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
